// File: rtl/routine_bus_pkg.sv
// Frame layout, seven-segment glyph table and FSM states shared by the routine bus receiver.
// Pure definitions: no logic, no latency, no flow control.
package routine_bus_pkg;

  localparam int FRAME_W = 46;
  localparam int RED_LSB = 36;
  localparam int RED_W   = 10;
  localparam int GRN_LSB = 28;
  localparam int GRN_W   = 8;
  localparam int HEX_W   = 7;   // digit d occupies [d*HEX_W +: HEX_W]

  // Active-low {g,f,e,d,c,b,a}; entry i is the glyph for hex digit i.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    COMMIT
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Maps one active-low segment field back to a hex nibble; blank decodes as 0.
// Combinational, zero latency, no flow control.
module seg7_to_hex
  import routine_bus_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    blank  = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/routine_bus_receiver.sv
// Receives 46-bit routine frames, validates the four segment fields and drives PWM-gated LED/hex pins.
// Frame accepted at edge N updates outputs at edge N+2; BusReady drops for two cycles per frame.
module routine_bus_receiver
  import routine_bus_pkg::*;
#(
  parameter int DIM_BITS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [FRAME_W-1:0]  BusIn,
  input  logic                BusValid,
  output logic                BusReady,
  input  logic [DIM_BITS-1:0] Brightness,
  output logic [RED_W-1:0]    LedRed,
  output logic [GRN_W-1:0]    LedGrn,
  output logic [HEX_W-1:0]    Hex3,
  output logic [HEX_W-1:0]    Hex2,
  output logic [HEX_W-1:0]    Hex1,
  output logic [HEX_W-1:0]    Hex0,
  output logic [15:0]         Digits,
  output logic [3:0]          Blank,
  output logic                FrameError,
  output logic [7:0]          FrameCount
);

  state_t state, state_nxt;
  logic   load, decode, commit, commit_ok, lit;

  logic [FRAME_W-1:0]  shadow;
  logic [3:0][3:0]     nib, dec_nib;
  logic [3:0]          legal, blank, dec_ok, dec_blank;
  logic [RED_W-1:0]    red_q, red_nxt;
  logic [GRN_W-1:0]    grn_q, grn_nxt;
  logic [3:0][6:0]     hex_q, hex_nxt, hex_pin;
  logic [DIM_BITS-1:0] pwm_cnt;

  for (genvar d = 0; d < 4; d++) begin : g_dec
    seg7_to_hex u_seg7_to_hex (
      .seg    (shadow[d*HEX_W +: HEX_W]),
      .nibble (nib[d]),
      .legal  (legal[d]),
      .blank  (blank[d])
    );
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    decode    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (BusValid && BusReady) begin
          load      = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        decode    = 1'b1;
        state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is registered so it stays low while reset is held.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      BusReady <= 1'b0;
    end else begin
      state    <= state_nxt;
      BusReady <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadow    <= '0;
      dec_nib   <= '0;
      dec_ok    <= '0;
      dec_blank <= '0;
    end else begin
      if (load) shadow <= BusIn;
      if (decode) begin
        dec_nib   <= nib;
        dec_ok    <= legal | blank;
        dec_blank <= blank;
      end
    end
  end

  assign commit_ok = commit && (&dec_ok);

  // Next display contents feed the pin registers so pins move on the commit edge.
  always_comb begin
    red_nxt = red_q;
    grn_nxt = grn_q;
    hex_nxt = hex_q;
    if (commit_ok) begin
      red_nxt = shadow[RED_LSB +: RED_W];
      grn_nxt = shadow[GRN_LSB +: GRN_W];
      for (int d = 0; d < 4; d++) hex_nxt[d] = shadow[d*HEX_W +: HEX_W];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      red_q      <= '0;
      grn_q      <= '0;
      hex_q      <= {4{SEG_BLANK}};
      Digits     <= '0;
      Blank      <= 4'b1111;
      FrameError <= 1'b0;
      FrameCount <= '0;
    end else begin
      red_q <= red_nxt;
      grn_q <= grn_nxt;
      hex_q <= hex_nxt;
      if (commit_ok) begin
        Digits     <= {dec_nib[3], dec_nib[2], dec_nib[1], dec_nib[0]};
        Blank      <= dec_blank;
        FrameError <= 1'b0;
        FrameCount <= FrameCount + 8'd1;
      end else if (commit) begin
        FrameError <= 1'b1;
      end
    end
  end

  assign lit = (&Brightness) || (pwm_cnt < Brightness);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pwm_cnt <= '0;
      LedRed  <= '0;
      LedGrn  <= '0;
      hex_pin <= {4{SEG_BLANK}};
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LedRed  <= lit ? red_nxt : '0;
      LedGrn  <= lit ? grn_nxt : '0;
      hex_pin <= lit ? hex_nxt : {4{SEG_BLANK}};
    end
  end

  assign Hex3 = hex_pin[3];
  assign Hex2 = hex_pin[2];
  assign Hex1 = hex_pin[1];
  assign Hex0 = hex_pin[0];

endmodule

// File: tb/tb_routine_bus_receiver.sv
// Directed self-checking bench for routine_bus_receiver.
module tb_routine_bus_receiver;

  localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30;
  localparam logic [6:0] P4 = 7'h19, P5 = 7'h12, P6 = 7'h02, P7 = 7'h78;
  localparam logic [6:0] P8 = 7'h00, P9 = 7'h10, PA = 7'h08, PB = 7'h03;
  localparam logic [6:0] PC = 7'h46, PD = 7'h21, PE = 7'h06, PF = 7'h0E;
  localparam logic [6:0] PBLANK = 7'h7F, PBAD = 7'h36;

  logic        Clock;
  logic        Reset;
  logic [45:0] BusIn;
  logic        BusValid;
  logic        BusReady;
  logic [3:0]  Brightness;
  logic [9:0]  LedRed;
  logic [7:0]  LedGrn;
  logic [6:0]  Hex3, Hex2, Hex1, Hex0;
  logic [15:0] Digits;
  logic [3:0]  Blank;
  logic        FrameError;
  logic [7:0]  FrameCount;

  int n_checks = 0;
  int n_fail   = 0;

  routine_bus_receiver #(.DIM_BITS(4)) dut (
    .Clock(Clock), .Reset(Reset), .BusIn(BusIn), .BusValid(BusValid), .BusReady(BusReady),
    .Brightness(Brightness), .LedRed(LedRed), .LedGrn(LedGrn),
    .Hex3(Hex3), .Hex2(Hex2), .Hex1(Hex1), .Hex0(Hex0),
    .Digits(Digits), .Blank(Blank), .FrameError(FrameError), .FrameCount(FrameCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [45:0] mk(input logic [9:0] r, input logic [7:0] g,
                                     input logic [6:0] h3, input logic [6:0] h2,
                                     input logic [6:0] h1, input logic [6:0] h0);
    return {r, g, h3, h2, h1, h0};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Offer a frame and return 1ns after the accepting edge.
  task automatic offer(input logic [45:0] f);
    bit done = 0;
    BusIn    = f;
    BusValid = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      if (BusReady) done = 1;
      tick();
    end
    BusValid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL offer_timeout: BusReady never seen, got 0 required 1");
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; BusValid = 1'b0; BusIn = '0; Brightness = 4'hF;
    tick(); tick(); tick();
    n_checks++; if (BusReady !== 1'b0)   begin n_fail++; $display("FAIL rst_ready: got %b required 0", BusReady); end
    n_checks++; if (LedRed !== 10'd0)    begin n_fail++; $display("FAIL rst_red: got %h required 0", LedRed); end
    n_checks++; if (Hex0 !== 7'h7F || Hex3 !== 7'h7F) begin n_fail++; $display("FAIL rst_hex: got %h/%h required 7f", Hex3, Hex0); end
    n_checks++; if (Blank !== 4'b1111)   begin n_fail++; $display("FAIL rst_blank: got %b required 1111", Blank); end
    n_checks++; if (FrameCount !== 8'd0 || FrameError !== 1'b0 || Digits !== 16'h0)
      begin n_fail++; $display("FAIL rst_counters: got cnt %0d err %b dig %h required 0 0 0", FrameCount, FrameError, Digits); end
    Reset = 1'b1;
    tick();
    n_checks++; if (BusReady !== 1'b1)   begin n_fail++; $display("FAIL rst_ready_release: got %b required 1", BusReady); end
  endtask

  task automatic test_basic();
    offer(mk(10'b1111000000, 8'b00001111, P3, P2, P1, P0));
    n_checks++; if (BusReady !== 1'b0)   begin n_fail++; $display("FAIL basic_ready_n1: got %b required 0", BusReady); end
    n_checks++; if (FrameCount !== 8'd0) begin n_fail++; $display("FAIL basic_early_cnt: got %0d required 0", FrameCount); end
    tick();
    n_checks++; if (BusReady !== 1'b0)   begin n_fail++; $display("FAIL basic_ready_n2: got %b required 0", BusReady); end
    n_checks++; if (Digits !== 16'h0)    begin n_fail++; $display("FAIL basic_early_dig: got %h required 0000", Digits); end
    tick();
    n_checks++; if (BusReady !== 1'b1)   begin n_fail++; $display("FAIL basic_ready_back: got %b required 1", BusReady); end
    n_checks++; if (LedRed !== 10'b1111000000) begin n_fail++; $display("FAIL basic_red: got %b required 1111000000", LedRed); end
    n_checks++; if (LedGrn !== 8'h0F)    begin n_fail++; $display("FAIL basic_grn: got %h required 0f", LedGrn); end
    n_checks++; if (Digits !== 16'h3210) begin n_fail++; $display("FAIL basic_digits: got %h required 3210", Digits); end
    n_checks++; if (Hex3 !== P3 || Hex0 !== P0) begin n_fail++; $display("FAIL basic_hex: got %h/%h required %h/%h", Hex3, Hex0, P3, P0); end
    n_checks++; if (FrameCount !== 8'd1 || FrameError !== 1'b0 || Blank !== 4'b0000)
      begin n_fail++; $display("FAIL basic_status: got cnt %0d err %b blank %b required 1 0 0000", FrameCount, FrameError, Blank); end
  endtask

  task automatic test_illegal();
    offer(mk(10'h3FF, 8'hFF, P8, PBAD, P5, PA));
    tick(); tick();
    n_checks++; if (FrameError !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b required 1", FrameError); end
    n_checks++; if (LedRed !== 10'b1111000000 || LedGrn !== 8'h0F)
      begin n_fail++; $display("FAIL bad_hold_leds: got %h/%h required 3c0/0f", LedRed, LedGrn); end
    n_checks++; if (Digits !== 16'h3210 || Hex2 !== P2) begin n_fail++; $display("FAIL bad_hold_digits: got %h hex2 %h required 3210 %h", Digits, Hex2, P2); end
    n_checks++; if (FrameCount !== 8'd1) begin n_fail++; $display("FAIL bad_hold_cnt: got %0d required 1", FrameCount); end
    offer(mk(10'h155, 8'hAA, P9, PC, PD, PE));
    tick(); tick();
    n_checks++; if (FrameError !== 1'b0) begin n_fail++; $display("FAIL bad_clear: got %b required 0", FrameError); end
    n_checks++; if (Digits !== 16'h9CDE || LedRed !== 10'h155) begin n_fail++; $display("FAIL bad_next: got %h red %h required 9cde 155", Digits, LedRed); end
    n_checks++; if (FrameCount !== 8'd2) begin n_fail++; $display("FAIL bad_next_cnt: got %0d required 2", FrameCount); end
  endtask

  task automatic test_blank();
    offer(mk(10'h001, 8'h80, P7, PB, PBLANK, PF));
    tick(); tick();
    n_checks++; if (Blank !== 4'b0010)   begin n_fail++; $display("FAIL blank_flags: got %b required 0010", Blank); end
    n_checks++; if (Digits !== 16'h7B0F) begin n_fail++; $display("FAIL blank_digits: got %h required 7b0f", Digits); end
    n_checks++; if (Hex1 !== 7'h7F || FrameCount !== 8'd3 || FrameError !== 1'b0)
      begin n_fail++; $display("FAIL blank_commit: got hex1 %h cnt %0d err %b required 7f 3 0", Hex1, FrameCount, FrameError); end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int accepts = 0;
    int bad_gaps = 0;
    do_reset();
    BusIn    = mk(10'h2AA, 8'h55, P4, P5, P6, P7);
    BusValid = 1'b1;
    for (int i = 0; i < 768; i++) begin
      if (i == 765) begin
        n_checks++; if (FrameCount !== 8'd255) begin n_fail++; $display("FAIL b2b_255: got %0d required 255", FrameCount); end
      end
      if (BusReady) begin
        if (prev >= 0 && (i - prev) != 3) bad_gaps++;
        prev = i;
        accepts++;
      end
      tick();
    end
    BusValid = 1'b0;
    n_checks++; if (accepts != 256)      begin n_fail++; $display("FAIL b2b_accepts: got %0d required 256", accepts); end
    n_checks++; if (bad_gaps != 0)       begin n_fail++; $display("FAIL b2b_gap: got %0d bad gaps required 0", bad_gaps); end
    n_checks++; if (FrameCount !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d required 0", FrameCount); end
    n_checks++; if (Digits !== 16'h4567) begin n_fail++; $display("FAIL b2b_digits: got %h required 4567", Digits); end
  endtask

  task automatic test_pwm();
    int on = 0;
    int wrong = 0;
    Brightness = 4'd4;
    tick();
    for (int i = 0; i < 32; i++) begin
      if (LedRed === 10'h2AA && Hex0 === P7) on++;
      else if (LedRed !== 10'h0 || Hex0 !== 7'h7F) wrong++;
      tick();
    end
    n_checks++; if (on != 8)    begin n_fail++; $display("FAIL pwm4_on: got %0d lit cycles required 8", on); end
    n_checks++; if (wrong != 0) begin n_fail++; $display("FAIL pwm4_dark: got %0d bad cycles required 0", wrong); end
    Brightness = 4'd0;
    offer(mk(10'h3FF, 8'hFF, P8, P9, PA, PB));
    tick(); tick();
    on = 0;
    for (int i = 0; i < 16; i++) begin
      if (LedRed !== 10'h0 || LedGrn !== 8'h0 || Hex0 !== 7'h7F) on++;
      tick();
    end
    n_checks++; if (on != 0)             begin n_fail++; $display("FAIL pwm0_dark: got %0d lit cycles required 0", on); end
    n_checks++; if (Digits !== 16'h89AB) begin n_fail++; $display("FAIL pwm0_digits: got %h required 89ab", Digits); end
    n_checks++; if (FrameCount !== 8'd1) begin n_fail++; $display("FAIL pwm0_cnt: got %0d required 1", FrameCount); end
  endtask

  task automatic test_reset_in_decode();
    Brightness = 4'hF;
    do_reset();
    offer(mk(10'h3FF, 8'hFF, P1, P2, P3, P4));
    Reset = 1'b0;
    #3;
    Reset = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++; if (FrameCount !== 8'd0) begin n_fail++; $display("FAIL rstdec_cnt: got %0d required 0", FrameCount); end
    n_checks++; if (Digits !== 16'h0 || LedRed !== 10'h0 || Blank !== 4'b1111)
      begin n_fail++; $display("FAIL rstdec_display: got dig %h red %h blank %b required 0 0 1111", Digits, LedRed, Blank); end
    n_checks++; if (BusReady !== 1'b1)   begin n_fail++; $display("FAIL rstdec_ready: got %b required 1", BusReady); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_blank();
    test_back_to_back();
    test_pwm();
    test_reset_in_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
